// File: rtl/bot_frame_sync.sv
// Shadow register stage: stages Rojobot register updates and commits them to the icon
// renderer only during vertical blanking, counting frames and coalesced updates.
module bot_frame_sync #(
    parameter int unsigned V_ACTIVE      = 480,
    parameter bit          COMMIT_ANY_VB = 1'b0,
    parameter logic [7:0]  RST_BOTINFO   = 8'h00,
    parameter logic [7:0]  RST_LOCX      = 8'd0,
    parameter logic [7:0]  RST_LOCY      = 8'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       upd_sysregs,
    input  logic [7:0] botinfo_in,
    input  logic [7:0] locx_in,
    input  logic [7:0] locy_in,
    input  logic [9:0] pixel_row,
    output logic [7:0] botinfo_reg,
    output logic [7:0] locx_reg,
    output logic [7:0] locy_reg,
    output logic       commit,
    output logic       pending,
    output logic [7:0] frame_cnt,
    output logic [7:0] drop_cnt
);

    typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_pending;
    logic       w_vblank;
    logic       w_vb_rise;
    logic       w_commit;
    logic       r_vblank_q;
    logic [7:0] r_stg_botinfo;
    logic [7:0] r_stg_locx;
    logic [7:0] r_stg_locy;
    logic [7:0] r_botinfo;
    logic [7:0] r_locx;
    logic [7:0] r_locy;
    logic       r_commit;
    logic [7:0] r_frame_cnt;
    logic [7:0] r_drop_cnt;

    assign w_vblank  = (pixel_row >= 10'(V_ACTIVE));
    assign w_vb_rise = w_vblank & ~r_vblank_q;
    assign w_commit  = w_pending & (COMMIT_ANY_VB ? w_vblank : w_vb_rise);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // upd_sysregs is a valid-only strobe with no ready: it is always accepted, and a
    // strobe coinciding with a commit keeps the staging set pending.
    always_comb begin
        w_state_nxt = r_state;
        if (upd_sysregs) begin
            w_state_nxt = ST_PEND;
        end else if (w_commit) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_pending = (r_state == ST_PEND);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vblank_q    <= 1'b1;
            r_stg_botinfo <= RST_BOTINFO;
            r_stg_locx    <= RST_LOCX;
            r_stg_locy    <= RST_LOCY;
            r_botinfo     <= RST_BOTINFO;
            r_locx        <= RST_LOCX;
            r_locy        <= RST_LOCY;
            r_commit      <= 1'b0;
            r_frame_cnt   <= 8'd0;
            r_drop_cnt    <= 8'd0;
        end else begin
            r_vblank_q <= w_vblank;
            r_commit   <= w_commit;
            if (upd_sysregs) begin
                r_stg_botinfo <= botinfo_in;
                r_stg_locx    <= locx_in;
                r_stg_locy    <= locy_in;
            end
            // Outputs take the staging value as it stood before any same-cycle capture.
            if (w_commit) begin
                r_botinfo <= r_stg_botinfo;
                r_locx    <= r_stg_locx;
                r_locy    <= r_stg_locy;
            end
            if (w_vb_rise) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
            if (upd_sysregs && w_pending && !w_commit && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    assign botinfo_reg = r_botinfo;
    assign locx_reg    = r_locx;
    assign locy_reg    = r_locy;
    assign commit      = r_commit;
    assign pending     = w_pending;
    assign frame_cnt   = r_frame_cnt;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_bot_frame_sync.sv
// Directed bench for bot_frame_sync: instance a commits on vblank rise only,
// instance b commits on any vblank cycle.
module tb_bot_frame_sync;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       upd_sysregs = 1'b0;
  logic [7:0] botinfo_in = 8'h00;
  logic [7:0] locx_in = 8'h00;
  logic [7:0] locy_in = 8'h00;
  logic [9:0] pixel_row = 10'd0;

  logic [7:0] a_botinfo, a_locx, a_locy, a_frame, a_drop;
  logic       a_commit, a_pending;
  logic [7:0] b_botinfo, b_locx, b_locy, b_frame, b_drop;
  logic       b_commit, b_pending;

  int total = 0;
  int bad = 0;

  bot_frame_sync #(.COMMIT_ANY_VB(1'b0)) dut_a (
    .clock(clock), .reset(reset), .upd_sysregs(upd_sysregs),
    .botinfo_in(botinfo_in), .locx_in(locx_in), .locy_in(locy_in),
    .pixel_row(pixel_row),
    .botinfo_reg(a_botinfo), .locx_reg(a_locx), .locy_reg(a_locy),
    .commit(a_commit), .pending(a_pending), .frame_cnt(a_frame), .drop_cnt(a_drop)
  );

  bot_frame_sync #(.COMMIT_ANY_VB(1'b1), .RST_BOTINFO(8'hA5)) dut_b (
    .clock(clock), .reset(reset), .upd_sysregs(upd_sysregs),
    .botinfo_in(botinfo_in), .locx_in(locx_in), .locy_in(locy_in),
    .pixel_row(pixel_row),
    .botinfo_reg(b_botinfo), .locx_reg(b_locx), .locy_reg(b_locy),
    .commit(b_commit), .pending(b_pending), .frame_cnt(b_frame), .drop_cnt(b_drop)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] bi, input logic [7:0] x, input logic [7:0] y);
    upd_sysregs = 1'b1;
    botinfo_in = bi;
    locx_in = x;
    locy_in = y;
    tick();
    upd_sysregs = 1'b0;
  endtask

  task automatic frame();
    pixel_row = 10'd100;
    tick();
    pixel_row = 10'd480;
    tick();
  endtask

  initial begin
    // Reset held in blanking
    reset = 1'b1;
    pixel_row = 10'd500;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_botinfo", a_botinfo, 8'h00);
    chk("rst_locx", a_locx, 8'h00);
    chk("rst_locy", a_locy, 8'h00);
    chk("rst_commit", a_commit, 1'b0);
    chk("rst_pending", a_pending, 1'b0);
    chk("rst_frame", a_frame, 8'd0);
    chk("rst_drop", a_drop, 8'd0);
    chk("rst_b_botinfo", b_botinfo, 8'hA5);
    repeat (3) tick();
    chk("rst_frame_hold", a_frame, 8'd0);

    // Basic commit at the 479->480 transition
    pixel_row = 10'd100;
    tick();
    strobe(8'h02, 8'h20, 8'h10);
    chk("basic_pending", a_pending, 1'b1);
    chk("basic_hold_locx", a_locx, 8'h00);
    pixel_row = 10'd479;
    tick();
    chk("basic_479_locx", a_locx, 8'h00);
    chk("basic_479_commit", a_commit, 1'b0);
    pixel_row = 10'd480;
    tick();
    chk("basic_commit", a_commit, 1'b1);
    chk("basic_locx", a_locx, 8'h20);
    chk("basic_locy", a_locy, 8'h10);
    chk("basic_botinfo", a_botinfo, 8'h02);
    chk("basic_pending_clr", a_pending, 1'b0);
    chk("basic_frame", a_frame, 8'd1);
    tick();
    chk("basic_commit_pulse", a_commit, 1'b0);

    // Coalesce three strobes in one active frame
    pixel_row = 10'd100;
    tick();
    strobe(8'h00, 8'd1, 8'd0);
    strobe(8'h00, 8'd2, 8'd0);
    strobe(8'h00, 8'd3, 8'd0);
    chk("coal_drop", a_drop, 8'd2);
    chk("coal_locx_hold", a_locx, 8'h20);
    pixel_row = 10'd480;
    tick();
    chk("coal_commit", a_commit, 1'b1);
    chk("coal_locx", a_locx, 8'd3);
    chk("coal_frame", a_frame, 8'd2);
    tick();
    chk("coal_single_pulse", a_commit, 1'b0);
    tick();
    chk("coal_no_recommit", a_commit, 1'b0);

    // Strobe colliding with the vb_rise commit cycle
    pixel_row = 10'd100;
    tick();
    strobe(8'h00, 8'd5, 8'd0);
    pixel_row = 10'd480;
    strobe(8'h00, 8'd6, 8'd0);
    chk("coll_commit", a_commit, 1'b1);
    chk("coll_locx_old", a_locx, 8'd5);
    chk("coll_pending", a_pending, 1'b1);
    chk("coll_drop", a_drop, 8'd2);
    tick();
    chk("coll_no_commit", a_commit, 1'b0);
    chk("coll_locx_hold", a_locx, 8'd5);
    frame();
    chk("coll_next_commit", a_commit, 1'b1);
    chk("coll_locx_new", a_locx, 8'd6);
    chk("coll_pending_clr", a_pending, 1'b0);
    chk("coll_frame", a_frame, 8'd4);

    // Strobe inside blanking: any-vblank commits, rise-only waits
    reset = 1'b1;
    pixel_row = 10'd490;
    tick();
    reset = 1'b0;
    strobe(8'h00, 8'd9, 8'd0);
    chk("anyvb_pending", b_pending, 1'b1);
    chk("anyvb_not_yet", b_commit, 1'b0);
    tick();
    chk("anyvb_commit", b_commit, 1'b1);
    chk("anyvb_locx", b_locx, 8'd9);
    chk("anyvb_pending_clr", b_pending, 1'b0);
    chk("rise_no_commit", a_commit, 1'b0);
    chk("rise_locx_hold", a_locx, 8'd0);
    repeat (4) tick();
    chk("rise_still_waiting", a_commit, 1'b0);
    chk("rise_still_pending", a_pending, 1'b1);
    frame();
    chk("rise_commit", a_commit, 1'b1);
    chk("rise_locx", a_locx, 8'd9);

    // Drop counter saturation
    pixel_row = 10'd100;
    tick();
    upd_sysregs = 1'b1;
    for (int i = 0; i < 300; i++) begin
      locx_in = 8'(i);
      tick();
      if (i == 99) chk("drop_100", a_drop, 8'd99);
    end
    upd_sysregs = 1'b0;
    chk("drop_sat", a_drop, 8'd255);

    // Mid-frame reset with a pending update discards it
    strobe(8'h07, 8'h77, 8'h66);
    chk("mid_pending_set", a_pending, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_pending_clr", a_pending, 1'b0);
    chk("mid_drop_clr", a_drop, 8'd0);
    chk("mid_frame_clr", a_frame, 8'd0);
    tick();
    pixel_row = 10'd480;
    tick();
    chk("mid_no_commit", a_commit, 1'b0);
    chk("mid_locx", a_locx, 8'd0);
    chk("mid_frame1", a_frame, 8'd1);

    // Frame counter wrap
    for (int f = 0; f < 254; f++) frame();
    chk("frame_255", a_frame, 8'd255);
    frame();
    chk("frame_wrap", a_frame, 8'd0);
    chk("wrap_locx_never", a_locx, 8'd0);
    chk("wrap_botinfo_never", a_botinfo, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
